// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register chain: DEPTH stages of WIDTH-bit payload with
// valid/ready on both ends. SKID=1 adds a per-stage skid entry so every ready
// is a flop output; SKID=0 lets ready ripple combinationally down the chain.
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int SKID  = 1,
    localparam int CAP  = DEPTH * (1 + SKID),
    localparam int OW   = $clog2(CAP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OW-1:0]    occupancy
);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [DEPTH-1:0]            rdy;   // stage k can take from its upstream
    logic [DEPTH-1:0]            up_v;
    logic [DEPTH-1:0][WIDTH-1:0] up_d;
    logic                        xfer_in, xfer_out;
    logic [OW-1:0]               occ_q, occ_d;

    // What each stage sees upstream: the chain input for stage 0, else the previous main reg
    always_comb begin
        up_v    = '0;
        up_d    = '0;
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v_q[k-1];
            up_d[k] = d_q[k-1];
        end
    end

    // Held low during reset and on flush so nothing is accepted into a clearing pipe
    assign in_ready  = rst & ~flush & rdy[0];
    assign xfer_in   = in_valid & in_ready;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];
    assign xfer_out  = out_valid & out_ready;
    assign occupancy = occ_q;

    // Entry count tracks handshakes directly; flush empties everything
    always_comb begin
        occ_d = occ_q + OW'(xfer_in) - OW'(xfer_out);
        if (flush) occ_d = '0;
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ_q <= '0;
        else      occ_q <= occ_d;
    end

    if (SKID != 0) begin : g_skid
        logic [DEPTH-1:0]            s_q, s_d;
        logic [DEPTH-1:0][WIDTH-1:0] sd_q, sd_d;
        logic [DEPTH-1:0]            dn_rdy;

        // Ready depends only on the skid flag, so no comb path from out_ready
        assign rdy = ~s_q;

        // Downstream ready of each stage: next stage's registered ready, or out_ready at the head
        always_comb begin
            dn_rdy          = '0;
            dn_rdy[DEPTH-1] = out_ready;
            for (int k = 0; k < DEPTH - 1; k++) dn_rdy[k] = rdy[k+1];
        end

        // Main/skid update: refill main from skid first so ordering stays FIFO
        always_comb begin
            v_d  = v_q;
            d_d  = d_q;
            s_d  = s_q;
            sd_d = sd_q;
            for (int k = 0; k < DEPTH; k++) begin
                if (v_q[k] && dn_rdy[k]) begin
                    if (s_q[k]) begin
                        d_d[k] = sd_q[k];
                        s_d[k] = 1'b0;
                    end else if (up_v[k] && rdy[k]) begin
                        d_d[k] = up_d[k];
                    end else begin
                        v_d[k] = 1'b0;
                    end
                end else if (up_v[k] && rdy[k]) begin
                    if (!v_q[k]) begin
                        v_d[k] = 1'b1;
                        d_d[k] = up_d[k];
                    end else begin
                        s_d[k]  = 1'b1;
                        sd_d[k] = up_d[k];
                    end
                end
            end
            // Flush drops all entries but leaves payload regs untouched
            if (flush) begin
                v_d  = '0;
                s_d  = '0;
                d_d  = d_q;
                sd_d = sd_q;
            end
        end

        // Stage registers
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q  <= '0;
                d_q  <= '0;
                s_q  <= '0;
                sd_q <= '0;
            end else begin
                v_q  <= v_d;
                d_q  <= d_d;
                s_q  <= s_d;
                sd_q <= sd_d;
            end
        end
    end else begin : g_flat
        // Ready ripples from the head back: a stage is free if empty or its successor moves
        always_comb begin
            rdy          = '0;
            rdy[DEPTH-1] = ~v_q[DEPTH-1] | out_ready;
            for (int k = DEPTH - 2; k >= 0; k--) rdy[k] = ~v_q[k] | rdy[k+1];
        end

        // A ready stage takes whatever its upstream offers, collapsing bubbles
        always_comb begin
            v_d = v_q;
            d_d = d_q;
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v_d[k] = up_v[k];
                    if (up_v[k]) d_d[k] = up_d[k];
                end
            end
            if (flush) begin
                v_d = '0;
                d_d = d_q;
            end
        end

        // Stage registers
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= '0;
                d_q <= '0;
            end else begin
                v_q <= v_d;
                d_q <= d_d;
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: a SKID=1 and a SKID=0 instance (DEPTH=2) share one
// stimulus stream; each is scored against a FIFO queue of accepted payloads.
module tb_pipe_reg_chain;
    localparam int W = 32;
    localparam int D = 2;

    logic         clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         sk_in_ready, sk_out_valid;
    logic [W-1:0] sk_out_data;
    logic [2:0]   sk_occ;
    logic         ns_in_ready, ns_out_valid;
    logic [W-1:0] ns_out_data;
    logic [1:0]   ns_occ;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q_sk[$];
    logic [W-1:0] q_ns[$];

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .SKID(1)) u_sk (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(sk_in_ready), .in_data(in_data),
        .out_valid(sk_out_valid), .out_ready(out_ready), .out_data(sk_out_data),
        .occupancy(sk_occ)
    );

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .SKID(0)) u_ns (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ns_in_ready), .in_data(in_data),
        .out_valid(ns_out_valid), .out_ready(out_ready), .out_data(ns_out_data),
        .occupancy(ns_occ)
    );

    // Advance the reference queues by the handshakes seen this cycle, then move past the edge
    task automatic step();
        if (sk_out_valid && out_ready && q_sk.size() > 0) q_sk.delete(0);
        if (in_valid && sk_in_ready) q_sk.push_back(in_data);
        if (ns_out_valid && out_ready && q_ns.size() > 0) q_ns.delete(0);
        if (in_valid && ns_in_ready) q_ns.push_back(in_data);
        if (flush) begin
            q_sk.delete();
            q_ns.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({sk_out_valid, sk_in_ready, sk_occ, sk_out_data} !== '0) begin
            errors++;
            $display("FAIL reset_sk: got v=%b r=%b occ=%0d d=%h want all 0", sk_out_valid, sk_in_ready, sk_occ, sk_out_data);
        end
        checks++;
        if ({ns_out_valid, ns_in_ready, ns_occ, ns_out_data} !== '0) begin
            errors++;
            $display("FAIL reset_ns: got v=%b r=%b occ=%0d d=%h want all 0", ns_out_valid, ns_in_ready, ns_occ, ns_out_data);
        end
        rst = 1'b1;
        q_sk.delete();
        q_ns.delete();
        @(posedge clk); #1;
        checks++;
        if (sk_in_ready !== 1'b1 || ns_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got sk=%b ns=%b want 1 1", sk_in_ready, ns_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] vals [0:2];
        logic [W-1:0] exp_d;
        logic         exp_v;
        int           peak;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        peak = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 3);
            if (c < 3) in_data = vals[c];
            @(negedge clk);
            exp_v = (c >= 2 && c <= 4);
            exp_d = '0;
            if (exp_v) exp_d = vals[c-2];
            checks++;
            if (sk_out_valid !== exp_v || (exp_v && sk_out_data !== exp_d)) begin
                errors++;
                $display("FAIL b2b_sk c%0d: got v=%b d=%h want v=%b d=%h", c, sk_out_valid, sk_out_data, exp_v, exp_d);
            end
            checks++;
            if (ns_out_valid !== exp_v || (exp_v && ns_out_data !== exp_d)) begin
                errors++;
                $display("FAIL b2b_ns c%0d: got v=%b d=%h want v=%b d=%h", c, ns_out_valid, ns_out_data, exp_v, exp_d);
            end
            checks++;
            if (sk_occ !== 3'(q_sk.size()) || ns_occ !== 2'(q_ns.size())) begin
                errors++;
                $display("FAIL b2b_occ c%0d: got sk=%0d ns=%0d want %0d %0d", c, sk_occ, ns_occ, q_sk.size(), q_ns.size());
            end
            if (int'(sk_occ) > peak) peak = int'(sk_occ);
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (peak !== 2) begin
            errors++;
            $display("FAIL b2b_peak: got %0d want 2", peak);
        end
    endtask

    task automatic test_fill_drain();
        int acc_sk = 0, acc_ns = 0, n_sk = 0, n_ns = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_data = $urandom;
            @(negedge clk);
            if (sk_in_ready) acc_sk++;
            if (ns_in_ready) acc_ns++;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (acc_sk != 4 || acc_ns != 2) begin
            errors++;
            $display("FAIL fill_count: got sk=%0d ns=%0d want 4 2", acc_sk, acc_ns);
        end
        checks++;
        if (sk_in_ready !== 1'b0 || ns_in_ready !== 1'b0 || sk_occ !== 3'd4 || ns_occ !== 2'd2) begin
            errors++;
            $display("FAIL fill_full: got r=%b%b occ=%0d/%0d want r=00 occ=4/2", sk_in_ready, ns_in_ready, sk_occ, ns_occ);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sk_out_valid) begin
                n_sk++;
                checks++;
                if (q_sk.size() == 0 || sk_out_data !== q_sk[0]) begin
                    errors++;
                    $display("FAIL drain_sk: got %h want %h", sk_out_data, (q_sk.size() > 0) ? q_sk[0] : 'x);
                end
            end
            if (ns_out_valid) begin
                n_ns++;
                checks++;
                if (q_ns.size() == 0 || ns_out_data !== q_ns[0]) begin
                    errors++;
                    $display("FAIL drain_ns: got %h want %h", ns_out_data, (q_ns.size() > 0) ? q_ns[0] : 'x);
                end
            end
            step();
        end
        checks++;
        if (n_sk != 4 || n_ns != 2 || sk_occ !== 3'd0 || ns_occ !== 2'd0 || sk_out_valid !== 1'b0 || ns_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: got n=%0d/%0d occ=%0d/%0d want n=4/2 occ=0/0", n_sk, n_ns, sk_occ, ns_occ);
        end
    endtask

    task automatic test_random();
        logic         sk_pv = 1'b0, sk_pr = 1'b0, ns_pv = 1'b0, ns_pr = 1'b0, r;
        logic [W-1:0] sk_pd = '0, ns_pd = '0;
        int           delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sk_pv && !sk_pr) begin
                checks++;
                if ({sk_out_valid, sk_out_data} !== {1'b1, sk_pd}) begin
                    errors++;
                    $display("FAIL stable_sk c%0d: got v=%b d=%h want v=1 d=%h", c, sk_out_valid, sk_out_data, sk_pd);
                end
            end
            if (ns_pv && !ns_pr) begin
                checks++;
                if ({ns_out_valid, ns_out_data} !== {1'b1, ns_pd}) begin
                    errors++;
                    $display("FAIL stable_ns c%0d: got v=%b d=%h want v=1 d=%h", c, ns_out_valid, ns_out_data, ns_pd);
                end
            end
            if (sk_out_valid && out_ready) begin
                delivered++;
                checks++;
                if (q_sk.size() == 0 || sk_out_data !== q_sk[0]) begin
                    errors++;
                    $display("FAIL order_sk c%0d: got %h want %h", c, sk_out_data, (q_sk.size() > 0) ? q_sk[0] : 'x);
                end
            end
            if (ns_out_valid && out_ready) begin
                checks++;
                if (q_ns.size() == 0 || ns_out_data !== q_ns[0]) begin
                    errors++;
                    $display("FAIL order_ns c%0d: got %h want %h", c, ns_out_data, (q_ns.size() > 0) ? q_ns[0] : 'x);
                end
            end
            checks++;
            if (sk_occ !== 3'(q_sk.size()) || ns_occ !== 2'(q_ns.size())) begin
                errors++;
                $display("FAIL occ_rand c%0d: got %0d/%0d want %0d/%0d", c, sk_occ, ns_occ, q_sk.size(), q_ns.size());
            end
            if (q_sk.size() == 4) begin
                checks++;
                if (sk_in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready_sk c%0d: got %b want 0", c, sk_in_ready);
                end
            end
            checks++;
            if (ns_in_ready !== (q_ns.size() < 2 || out_ready)) begin
                errors++;
                $display("FAIL ready_ns c%0d: got %b want %b", c, ns_in_ready, (q_ns.size() < 2 || out_ready));
            end
            // in_ready of the skid variant must not follow out_ready within the cycle
            r = sk_in_ready;
            out_ready = ~out_ready;
            #1;
            checks++;
            if (sk_in_ready !== r) begin
                errors++;
                $display("FAIL ready_comb_sk c%0d: got %b want %b", c, sk_in_ready, r);
            end
            out_ready = ~out_ready;
            #1;
            sk_pv = sk_out_valid; sk_pr = out_ready; sk_pd = sk_out_data;
            ns_pv = ns_out_valid; ns_pr = out_ready; ns_pd = ns_out_data;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (sk_out_valid) begin
                checks++;
                if (q_sk.size() == 0 || sk_out_data !== q_sk[0]) begin
                    errors++;
                    $display("FAIL rdrain_sk: got %h want %h", sk_out_data, (q_sk.size() > 0) ? q_sk[0] : 'x);
                end
            end
            step();
        end
        checks++;
        if (delivered < 1000 || sk_occ !== 3'd0 || q_sk.size() != 0 || ns_occ !== 2'd0) begin
            errors++;
            $display("FAIL rand_end: got delivered=%0d occ=%0d/%0d want >=1000 0/0", delivered, sk_occ, ns_occ);
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] hd_sk, hd_ns;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = $urandom;
            @(negedge clk);
            step();
        end
        checks++;
        if (sk_occ !== 3'd3 || ns_occ !== 2'd2) begin
            errors++;
            $display("FAIL flush_pre: got occ=%0d/%0d want 3/2", sk_occ, ns_occ);
        end
        hd_sk = q_sk[0];
        hd_ns = q_ns[0];
        flush = 1'b1;
        out_ready = 1'b1;
        in_data = $urandom;
        @(negedge clk);
        checks++;
        if (sk_in_ready !== 1'b0 || ns_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b%b want 00", sk_in_ready, ns_in_ready);
        end
        checks++;
        if ({sk_out_valid, sk_out_data} !== {1'b1, hd_sk} || {ns_out_valid, ns_out_data} !== {1'b1, hd_ns}) begin
            errors++;
            $display("FAIL flush_head: got %h/%h want %h/%h", sk_out_data, ns_out_data, hd_sk, hd_ns);
        end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({sk_out_valid, sk_occ, sk_in_ready} !== 5'b0_000_1 || {ns_out_valid, ns_occ, ns_in_ready} !== 4'b0_00_1) begin
            errors++;
            $display("FAIL flush_after: got sk v=%b occ=%0d r=%b ns v=%b occ=%0d r=%b want 0 0 1", sk_out_valid, sk_occ, sk_in_ready, ns_out_valid, ns_occ, ns_in_ready);
        end
        step();
        in_valid = 1'b1;
        in_data  = 32'hA5A5_5A5A;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (sk_out_valid !== (c == D) || (c == D && sk_out_data !== 32'hA5A5_5A5A)) begin
                errors++;
                $display("FAIL flush_refill c%0d: got v=%b d=%h want v=%b d=a5a55a5a", c, sk_out_valid, sk_out_data, (c == D));
            end
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_data = $urandom;
            @(negedge clk);
            step();
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({sk_out_valid, sk_in_ready, sk_occ, sk_out_data} !== '0) begin
            errors++;
            $display("FAIL arst_sk: got v=%b r=%b occ=%0d d=%h want all 0", sk_out_valid, sk_in_ready, sk_occ, sk_out_data);
        end
        checks++;
        if ({ns_out_valid, ns_in_ready, ns_occ, ns_out_data} !== '0) begin
            errors++;
            $display("FAIL arst_ns: got v=%b r=%b occ=%0d d=%h want all 0", ns_out_valid, ns_in_ready, ns_occ, ns_out_data);
        end
        q_sk.delete();
        q_ns.delete();
        in_valid = 1'b0;
        #4 rst = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hC0DE_0001;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (sk_out_valid !== (c == D) || ns_out_valid !== (c == D) ||
                (c == D && (sk_out_data !== 32'hC0DE_0001 || ns_out_data !== 32'hC0DE_0001))) begin
                errors++;
                $display("FAIL arst_latency c%0d: got v=%b%b d=%h want v=%b d=c0de0001", c, sk_out_valid, ns_out_valid, sk_out_data, (c == D));
            end
            step();
            in_valid = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_fill_drain();
        test_random();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
